// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding,
// slice-width helper and the full-adder cell used by every ripple slice.
package pipelined_add_sub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int slice_w(input int n, input int stages);
    return n / stages;
  endfunction

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/pipelined_add_sub_slice.sv
// Combinational W-bit ripple chain of full-adder cells; c_msb_in is the carry
// entering the top bit so the last slice can form signed overflow.
module pipelined_add_sub_slice
  import pipelined_add_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         cin,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         cout,
  output logic [W-1:0] sum,
  output logic         c_msb_in
);

  always_comb begin : ripple
    logic [W:0] c;
    c        = '0;
    sum      = '0;
    c[0]     = cin;
    for (int i = 0; i < W; i++) begin
      {c[i+1], sum[i]} = full_add(x[i], y[i], c[i]);
    end
    cout     = c[W];
    c_msb_in = c[W-1];
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: STAGES ripple slices with the carry
// registered between them and a single global advance for valid/ready flow.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         cin,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = slice_w(N, STAGES);

  if (N % STAGES != 0 || STAGES < 1 || STAGES > N) begin : g_bad_cfg
    $error("pipelined_add_sub: STAGES must divide N and lie in 1..N");
  end

  // Handshake: a beat transfers on a side when valid & ready are both high in the
  // same cycle; the whole pipe shifts together whenever the output slot is free.
  logic adv;

  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0]         carry_q;
  logic [STAGES-1:0][N-1:0]  x_q, x_d;
  logic [STAGES-1:0][N-1:0]  y_q, y_d;
  logic [STAGES-1:0][N-1:0]  sum_q, sum_d;
  logic [STAGES-1:0]         cin_s;
  logic [STAGES-1:0][N-1:0]  psum_s;
  logic                      ovf_q;

  logic [STAGES-1:0][W-1:0]  slice_sum;
  logic [STAGES-1:0]         slice_cout;
  logic [STAGES-1:0]         slice_cmsb;

  // Stage k inputs come from the ports (k=0) or from stage k-1's registers; the
  // x/y words hold the skewed upper operand slices, sum holds the deskewed lower results.
  always_comb begin
    vld_d  = '0;
    x_d    = '0;
    y_d    = '0;
    cin_s  = '0;
    psum_s = '0;
    sum_d  = '0;
    vld_d[0]  = in_valid;
    x_d[0]    = x;
    y_d[0]    = y ^ {N{sub == SUB}};
    cin_s[0]  = (sub == ADD) ? cin : ~cin;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      x_d[k]    = x_q[k-1];
      y_d[k]    = y_q[k-1];
      cin_s[k]  = carry_q[k-1];
      psum_s[k] = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]            = psum_s[k];
      sum_d[k][k*W +: W]  = slice_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipelined_add_sub_slice #(.W(W)) u_slice (
      .cin      (cin_s[k]),
      .x        (x_d[k][k*W +: W]),
      .y        (y_d[k][k*W +: W]),
      .cout     (slice_cout[k]),
      .sum      (slice_sum[k]),
      .c_msb_in (slice_cmsb[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      vld_q   <= vld_d;
      carry_q <= slice_cout;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      ovf_q   <= slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
    end
  end

  assign adv       = ~(out_valid & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  // Operands leaving the last stage and lower-slice top carries have no consumer.
  logic unused_tail;
  assign unused_tail = ^{x_q[STAGES-1], y_q[STAGES-1], slice_cmsb};

endmodule
